// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side byte buffer.
package uart_pkg;

    localparam int UART_DW     = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 2048;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port, transmitter handshake and error flags of uart_tx_fifo.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               wr_en;
    logic [UART_DW-1:0] wr_data;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic               newd;
    logic [UART_DW-1:0] datatx;
    logic               donetx;
    logic               overflow;
    logic               tx_timeout;
    logic               clr_err;

    // Environment side: host writer plus the UART transmitter.
    modport master (
        output wr_en, wr_data, donetx, clr_err,
        input  full, empty, count, newd, datatx, overflow, tx_timeout
    );

    // Buffer side.
    modport slave (
        input  wr_en, wr_data, donetx, clr_err,
        output full, empty, count, newd, datatx, overflow, tx_timeout
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO: storage, wrapping pointers, occupancy count.
// Writes while full are dropped and reported on wr_drop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [UART_DW-1:0]   wr_data,
    input  logic                 rd_en,
    output logic [UART_DW-1:0]   rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                 wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               wr_ok;
    logic               rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign wr_drop = wr_en && full;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and transmit sequencer in front of the UART transmitter.
// Pops one byte, strobes newd, waits for donetx (or a timeout), repeats.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    tx_state_t          state;
    logic [TW-1:0]      tmo_cnt;
    logic               pop;
    logic               wr_drop;
    logic [UART_DW-1:0] head;

    assign pop = (state == S_IDLE) && !bus.empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (bus.full),
        .empty   (bus.empty),
        .count   (bus.count),
        .wr_drop (wr_drop)
    );

    // Sticky overflow: a set on the same edge as clr_err wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.overflow <= 1'b0;
        end else if (wr_drop) begin
            bus.overflow <= 1'b1;
        end else if (bus.clr_err) begin
            bus.overflow <= 1'b0;
        end
    end

    // Transmit sequencer with registered newd/datatx and sticky timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            tmo_cnt        <= '0;
            bus.newd       <= 1'b0;
            bus.datatx     <= '0;
            bus.tx_timeout <= 1'b0;
        end else begin
            bus.newd <= 1'b0;
            if (bus.clr_err) begin
                bus.tx_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.datatx <= head;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    bus.newd <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.donetx) begin
                        state <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.tx_timeout <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: two instances (long and short timeout)
// driven with shared host traffic, each compared every cycle against a
// queue-based model of the buffer and transmit timing.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int TMO0  = 2048;
    localparam int TMO1  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_err;
    logic       dn [2];

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus0 ();
    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus1 ();

    assign bus0.wr_en   = wr_en;
    assign bus0.wr_data = wr_data;
    assign bus0.clr_err = clr_err;
    assign bus0.donetx  = dn[0];
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_data = wr_data;
    assign bus1.clr_err = clr_err;
    assign bus1.donetx  = dn[1];

    uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TMO0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TMO1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [4:0] o_count [2];
    logic       o_full  [2];
    logic       o_empty [2];
    logic       o_newd  [2];
    logic [7:0] o_dat   [2];
    logic       o_ovf   [2];
    logic       o_tmo   [2];

    assign o_count[0] = bus0.count;  assign o_count[1] = bus1.count;
    assign o_full[0]  = bus0.full;   assign o_full[1]  = bus1.full;
    assign o_empty[0] = bus0.empty;  assign o_empty[1] = bus1.empty;
    assign o_newd[0]  = bus0.newd;   assign o_newd[1]  = bus1.newd;
    assign o_dat[0]   = bus0.datatx; assign o_dat[1]   = bus1.datatx;
    assign o_ovf[0]   = bus0.overflow;   assign o_ovf[1] = bus1.overflow;
    assign o_tmo[0]   = bus0.tx_timeout; assign o_tmo[1] = bus1.tx_timeout;

    // Reference model: pending bytes, the byte on the wire, and the number
    // of edges since it was popped (strobe one edge later, waiting after).
    logic [7:0] mq [2][$];
    bit         m_busy [2];
    int         m_age  [2];
    logic [7:0] m_dat  [2];
    bit         m_ovf  [2];
    bit         m_tmo  [2];
    int         tmo_lim [2];
    int         dly [2];      // donetx returned once age reaches dly; 0 = never
    bit         spur;         // stray donetx while the transmitter is not waited on

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_edge(input int k);
        int  sz;
        bit  hit;
        sz  = mq[k].size();
        hit = 1'b0;
        if (!rst) begin
            mq[k].delete();
            m_busy[k] = 1'b0;
            m_age[k]  = 0;
            m_dat[k]  = 8'h00;
            m_ovf[k]  = 1'b0;
            m_tmo[k]  = 1'b0;
        end else begin
            if (wr_en && sz == DEPTH) m_ovf[k] = 1'b1;
            else if (clr_err)         m_ovf[k] = 1'b0;
            if (m_busy[k]) begin
                if (m_age[k] >= 1 && dn[k]) begin
                    m_busy[k] = 1'b0;
                end else if (m_age[k] == tmo_lim[k]) begin
                    m_busy[k] = 1'b0;
                    hit = 1'b1;
                end else begin
                    m_age[k]++;
                end
            end else if (sz > 0) begin
                m_dat[k]  = mq[k].pop_front();
                m_busy[k] = 1'b1;
                m_age[k]  = 0;
            end
            if (hit)          m_tmo[k] = 1'b1;
            else if (clr_err) m_tmo[k] = 1'b0;
            if (wr_en && sz < DEPTH) mq[k].push_back(wr_data);
        end
    endtask

    task automatic compare(input int k);
        int sz;
        sz = mq[k].size();
        check_eq($sformatf("count%0d", k), o_count[k], sz);
        check_eq($sformatf("full%0d", k),  o_full[k],  (sz == DEPTH) ? 1 : 0);
        check_eq($sformatf("empty%0d", k), o_empty[k], (sz == 0) ? 1 : 0);
        check_eq($sformatf("newd%0d", k),  o_newd[k],  (m_busy[k] && m_age[k] == 1) ? 1 : 0);
        check_eq($sformatf("datatx%0d", k), o_dat[k],  m_dat[k]);
        check_eq($sformatf("overflow%0d", k), o_ovf[k], m_ovf[k]);
        check_eq($sformatf("tx_timeout%0d", k), o_tmo[k], m_tmo[k]);
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            dn[k] = (m_busy[k] && m_age[k] >= 1 && dly[k] != 0 && m_age[k] >= dly[k])
                  || (spur && !(m_busy[k] && m_age[k] >= 1));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    task automatic put(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; spur = 1'b0;
        dn[0] = 1'b0; dn[1] = 1'b0;
        tmo_lim[0] = TMO0; tmo_lim[1] = TMO1;
        dly[0] = 11; dly[1] = 11;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_age[k] = 0; m_dat[k] = 8'h00;
            m_ovf[k] = 1'b0; m_tmo[k] = 1'b0;
        end

        idle(3);
        rst = 1'b1;
        idle(2);

        // Single byte, then back-to-back three bytes.
        put(8'hA5);
        idle(20);
        put(8'h01); put(8'h02); put(8'h03);
        idle(60);

        // Fill with the transmitter stalled, then write into a full buffer.
        dly[0] = 0; dly[1] = 0;
        for (int i = 0; i < DEPTH + 1; i++) put(8'h10 + 8'(i));
        put(8'hFF);
        put(8'hFF);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        idle(3);
        dly[0] = 11; dly[1] = 3;
        idle(320);

        // Fast turnaround: writes coincide with pops at low occupancy.
        dly[0] = 1; dly[1] = 1;
        for (int i = 0; i < 40; i++) begin
            put(8'(i * 7 + 3));
            idle(2);
        end
        idle(20);

        // Reset while a byte is in flight and more are queued.
        dly[0] = 0; dly[1] = 0;
        for (int i = 0; i < 6; i++) put(8'hC0 + 8'(i));
        idle(3);
        rst = 1'b0; tick(); rst = 1'b1;
        idle(30);

        // Randomised traffic, completion latency, stray donetx, clears.
        for (int i = 0; i < 1600; i++) begin
            if (i % 50 == 0) begin
                dly[0] = int'($urandom_range(1, 12));
                dly[1] = int'($urandom_range(0, 12));
            end
            wr_en   = ($urandom_range(0, 99) < ((i % 400) < 100 ? 80 : 30));
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 99) < 3);
            spur    = ($urandom_range(0, 99) < 5);
            tick();
        end
        wr_en = 1'b0; clr_err = 1'b0; spur = 1'b0;
        dly[0] = 4; dly[1] = 4;
        idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
